// File: rtl/field_cfg_dumper.sv
// Reads the live field back in row-major order, one cell per cycle, and packs 8 cells per byte LSB first.
// Each byte is held on a valid/ready stream until accepted; no reads are issued while a byte waits.
module field_cfg_dumper #(
  parameter int FIELD_W = 64,
  parameter int FIELD_H = 48,
  localparam int X_ADR_SIZE = (FIELD_W > 1) ? $clog2(FIELD_W) : 1,
  localparam int Y_ADR_SIZE = (FIELD_H > 1) ? $clog2(FIELD_H) : 1,
  localparam int N_BYTES    = (FIELD_W * FIELD_H + 7) / 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_go,
  output logic [X_ADR_SIZE-1:0] o_rd_x,
  output logic [Y_ADR_SIZE-1:0] o_rd_y,
  output logic                  o_rd_en,
  input  logic                  i_rd_cell,
  output logic [7:0]            o_byte,
  output logic                  o_byte_valid,
  input  logic                  i_byte_ready,
  output logic                  o_is_dumping,
  output logic                  o_done
);

  localparam int CNT_W = $clog2(N_BYTES + 1);
  localparam logic [X_ADR_SIZE-1:0] X_LAST    = X_ADR_SIZE'(FIELD_W - 1);
  localparam logic [Y_ADR_SIZE-1:0] Y_LAST    = Y_ADR_SIZE'(FIELD_H - 1);
  localparam logic [CNT_W-1:0]      BYTE_LAST = CNT_W'(N_BYTES - 1);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, SEND} state_t;

  state_t                  state_q, state_d;
  logic [X_ADR_SIZE-1:0]   x_q, x_d, x_nxt;
  logic [Y_ADR_SIZE-1:0]   y_q, y_d, y_nxt;
  logic [2:0]              bit_q, bit_d;
  logic [2:0]              cap_q, cap_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [7:0]              sr_q, sr_d;
  logic [7:0]              byte_q, byte_d;
  logic                    rd_en_q, rd_en_d;
  logic                    rd_vld_q, rd_vld_d;
  logic                    vld_q, vld_d;
  logic                    dump_q, dump_d;
  logic                    done_q, done_d;
  logic                    last_cell;

  // Shared raster step: x wraps to 0 and bumps y.
  always_comb begin
    x_nxt = x_q + 1'b1;
    y_nxt = y_q;
    if (x_q == X_LAST) begin
      x_nxt = '0;
      y_nxt = y_q + 1'b1;
    end
  end

  assign last_cell = (x_q == X_LAST) && (y_q == Y_LAST);

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    bit_d    = bit_q;
    cnt_d    = cnt_q;
    sr_d     = sr_q;
    byte_d   = byte_q;
    rd_en_d  = 1'b0;
    vld_d    = vld_q;
    dump_d   = dump_q;
    done_d   = 1'b0;
    rd_vld_d = rd_en_q;
    cap_d    = bit_q;

    // Cell data trails the read strobe by one cycle, so its bit slot is the delayed index.
    if (rd_vld_q) sr_d[cap_q] = i_rd_cell;

    unique case (state_q)
      IDLE: begin
        if (i_go) begin
          state_d = FETCH;
          x_d     = '0;
          y_d     = '0;
          bit_d   = '0;
          cnt_d   = '0;
          sr_d    = '0;
          rd_en_d = 1'b1;
          dump_d  = 1'b1;
        end
      end
      FETCH: begin
        bit_d = bit_q + 3'd1;
        if (bit_q == 3'd7 || last_cell) state_d = DRAIN;
        else                            rd_en_d = 1'b1;
        if (!last_cell) begin
          x_d = x_nxt;
          y_d = y_nxt;
        end
      end
      DRAIN: begin
        state_d = SEND;
        byte_d  = sr_d;
        vld_d   = 1'b1;
      end
      SEND: begin
        if (i_byte_ready) begin
          vld_d = 1'b0;
          if (cnt_q < BYTE_LAST) begin
            state_d = FETCH;
            cnt_d   = cnt_q + 1'b1;
            bit_d   = '0;
            sr_d    = '0;
            rd_en_d = 1'b1;
          end else begin
            state_d = IDLE;
            dump_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      x_q      <= '0;
      y_q      <= '0;
      bit_q    <= '0;
      cap_q    <= '0;
      cnt_q    <= '0;
      sr_q     <= '0;
      byte_q   <= '0;
      rd_en_q  <= 1'b0;
      rd_vld_q <= 1'b0;
      vld_q    <= 1'b0;
      dump_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      bit_q    <= bit_d;
      cap_q    <= cap_d;
      cnt_q    <= cnt_d;
      sr_q     <= sr_d;
      byte_q   <= byte_d;
      rd_en_q  <= rd_en_d;
      rd_vld_q <= rd_vld_d;
      vld_q    <= vld_d;
      dump_q   <= dump_d;
      done_q   <= done_d;
    end
  end

  assign o_rd_x       = x_q;
  assign o_rd_y       = y_q;
  assign o_rd_en      = rd_en_q;
  assign o_byte       = byte_q;
  assign o_byte_valid = vld_q;
  assign o_is_dumping = dump_q;
  assign o_done       = done_q;

endmodule

// File: doc/field_cfg_dumper.md
# field_cfg_dumper

Scans the whole Game of Life field in row-major order, reads one cell per cycle from the field memory's read port, and packs the cells into bytes. Bytes go out on a valid/ready byte stream, normally a UART transmitter. It is the save/export counterpart to the configuration loader: the loader writes a field from a stored configuration, and this block reads the live field back out in the same coordinate order. It sits between the field memory and the host-link transmitter and is started by a single-cycle `i_go`.

## Interface
- `FIELD_W`, default 64: field width in cells, ≥ 1.
- `FIELD_H`, default 48: field height in cells, ≥ 1.
- `X_ADR_SIZE`, localparam: `$clog2(FIELD_W)`.
- `Y_ADR_SIZE`, localparam: `$clog2(FIELD_H)`.
- `N_BYTES`, localparam: ceil(FIELD_W·FIELD_H / 8).

Ports:
- `clk`  in  1: single clock; all logic is on its rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `i_go`  in  1: start request; sampled only in IDLE.
- `o_rd_x`  out  X_ADR_SIZE: field read column.
- `o_rd_y`  out  Y_ADR_SIZE: field read row.
- `o_rd_en`  out  1: read strobe; the coordinates are valid while it is high.
- `i_rd_cell`  in  1: cell state, valid exactly 1 cycle after `o_rd_en`.
- `o_byte`  out  8: packed cells.
- `o_byte_valid`  out  1: byte available.
- `i_byte_ready`  in  1: the sink accepts the byte.
- `o_is_dumping`  out  1: high from start through the final byte handshake.
- `o_done`  out  1: one-cycle pulse after the last byte is accepted.

## Operation
- Scan order is x from 0 to FIELD_W-1, then y+1, from (0,0) to (FIELD_W-1, FIELD_H-1).
  - Wrap rules are identical to the shared next-coordinate logic.
  - The block reuses that logic instead of duplicating it.
- Packing: the k-th cell of each group of 8 goes in bit k, LSB first.
  - In the final partial byte, unused high bits are 0.
- FSM states:
  - IDLE: `i_go`=1 → FETCH, and coordinates, bit index and byte counter are cleared. `i_go`=0 → stay.
  - FETCH: assert `o_rd_en` with the current coordinates and advance the coordinates every cycle. Leave for DRAIN after 8 reads, or after the read of the last cell.
  - DRAIN: one cycle. Capture the last `i_rd_cell` and latch the completed byte.
  - SEND: `o_byte_valid`=1 and `o_byte` is stable. On `o_byte_valid & i_byte_ready`:
    - if the byte counter is less than N_BYTES-1 → FETCH with the shift register cleared;
    - otherwise → IDLE with `o_done` pulsed.
- Read data is shifted in on every cycle following an `o_rd_en` cycle, including the transition from FETCH to DRAIN.
- `i_go` is ignored outside IDLE. `i_rd_cell` is ignored when no read was issued in the previous cycle.
- `o_rd_en` is never high in DRAIN, SEND or IDLE. No read is issued while a byte is waiting in SEND.
- Counters:
  - bit index: 3 bits;
  - byte counter: `$clog2(N_BYTES+1)` bits;
  - coordinates use the same widths as the ports.
- There is no overflow: the last-cell condition ends FETCH before any coordinate wraps.

## Timing
- Reset values: `o_rd_x`=0, `o_rd_y`=0, `o_rd_en`=0, `o_byte`=0x00, `o_byte_valid`=0, `o_is_dumping`=0, `o_done`=0. State is IDLE.
- All outputs are registered; none depends combinationally on an input.
- `i_go` is high in cycle 0. From cycle 1:
  - cycle 1: FETCH begins and `o_rd_en` rises with (0,0);
  - cycles 1–8: reads;
  - cycle 9: DRAIN;
  - cycle 10: SEND.
- `o_is_dumping` rises in cycle 1. It falls, and `o_done` pulses, in the cycle after the final handshake.
- With `i_byte_ready` tied high, a full byte takes 10 cycles. A final byte of m cells takes m+2 cycles.
- Backpressure: SEND holds indefinitely; `o_byte` and `o_byte_valid` must not change until the handshake.
- `i_go` asserted in the same cycle as `o_done`: the block is in IDLE, so the request is accepted and a new dump starts the next cycle.
- `rst_n` low at any point, including mid-FETCH or mid-SEND:
  - all outputs return to their reset values asynchronously;
  - the partial dump is abandoned and no `o_done` is issued;
  - after release, the block needs a new `i_go`.

## Test plan
- Full bytes: W=8, H=2, field row 0 = bits of 0xA5, row 1 = bits of 0x3C, ready tied high. Required:
  - `i_go` → bytes 0xA5 then 0x3C;
  - reads at (0..7,0) then (0..7,1);
  - `o_done` one cycle after the second handshake;
  - exactly 16 `o_rd_en` cycles.
- Partial byte: W=5, H=3, all cells 1. Required:
  - bytes 0xFF then 0x7F;
  - second byte bit 7 = 0;
  - total of 15 reads, the last at (4,2).
- Backpressure: W=8, H=1, cells = 0x81, `i_byte_ready` low for 6 cycles after valid. Required:
  - `o_byte`=0x81 held with valid for 6 cycles;
  - no `o_rd_en` during the stall;
  - handshake on the first ready cycle.
- `i_go` while busy: pulse `i_go` in cycle 4 of a dump. Required: no restart, coordinate sequence unchanged, a single `o_done`.
- Reset mid-dump: deassert `rst_n` during the 2nd FETCH of W=8, H=2. Required:
  - all outputs are at reset values in the same cycle;
  - no byte and no `o_done` afterwards;
  - a new `i_go` reproduces the full 0xA5, 0x3C sequence.
- Back-to-back: `i_go` held high continuously on W=8, H=1. Required: a second dump starts in the cycle after `o_done`, and the byte stream repeats identically.
